// File: rtl/axi_rd_resp.sv
// Purpose: AXI4 read responder; queues AR commands and walks each burst against a sync-read word memory.
// Latency: AR handshake at edge N -> RVALID high after edge N+4; 3 cycles/beat (2 for SLVERR bursts).
// Backpressure: ARREADY drops when the command FIFO is full; RVALID/R* hold stable until RREADY.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   AR* (ARID..ARVALID), ARREADY     read-address channel; ARREGION is accepted and ignored
//   RID, RDATA, RRESP, RLAST, RVALID, RREADY   read-data channel
//   mem_rd_en, mem_rd_addr           word-addressed read strobe to storage
//   mem_rd_data                      storage data, valid the cycle after mem_rd_en
module axi_rd_resp #(
  parameter int ARID_WIDTH   = 4,
  parameter int ARADDR_WIDTH = 10,
  parameter int RDATA_WIDTH  = 64,
  parameter int CMD_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ARID_WIDTH-1:0]   ARID,
  input  logic [ARADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [3:0]              ARREGION,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ARID_WIDTH-1:0]   RID,
  output logic [RDATA_WIDTH-1:0]  RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    mem_rd_en,
  output logic [ARADDR_WIDTH-$clog2(RDATA_WIDTH/8)-1:0] mem_rd_addr,
  input  logic [RDATA_WIDTH-1:0]  mem_rd_data
);

  localparam int NB = RDATA_WIDTH / 8;
  localparam int WB = $clog2(NB);
  localparam int AW = ARADDR_WIDTH;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam logic [2:0] WB_SZ = 3'(WB);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef struct packed {
    logic [ARID_WIDTH-1:0] id;
    logic [AW-1:0]         addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_CAPT,
    S_DATA
  } state_t;

  // ---------------------------------------------------------------- command FIFO
  cmd_t          r_fifo [CMD_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_pop;
  cmd_t          w_push_cmd;
  cmd_t          w_head_cmd;

  assign w_fifo_full  = (r_count == (PW+1)'(CMD_DEPTH));
  assign w_fifo_empty = (r_count == '0);
  assign ARREADY      = !rst && !w_fifo_full;
  assign w_push       = ARVALID && ARREADY;
  assign w_push_cmd   = '{id: ARID, addr: ARADDR, len: ARLEN, size: ARSIZE, burst: ARBURST};
  assign w_head_cmd   = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_cmd;
  end

  // ---------------------------------------------------------------- error decode on FIFO head
  logic [AW-1:0] w_size_mask;
  logic          w_wrap_len_ok;
  logic          w_head_err;

  assign w_size_mask   = (AW'(1) << w_head_cmd.size) - AW'(1);
  assign w_wrap_len_ok = (w_head_cmd.len == 8'd1) || (w_head_cmd.len == 8'd3) ||
                         (w_head_cmd.len == 8'd7) || (w_head_cmd.len == 8'd15);
  assign w_head_err    = (w_head_cmd.burst == BURST_RSVD) ||
                         (w_head_cmd.size > WB_SZ) ||
                         ((w_head_cmd.burst == BURST_WRAP) &&
                          (!w_wrap_len_ok || ((w_head_cmd.addr & w_size_mask) != '0)));

  // ---------------------------------------------------------------- FSM
  state_t r_state;
  state_t w_state_nxt;
  logic   w_mem_rd_en;

  logic [ARID_WIDTH-1:0]  r_id;
  logic [AW-1:0]          r_addr;
  logic [7:0]             r_len;
  logic [2:0]             r_size;
  logic [1:0]             r_burst;
  logic                   r_err;
  logic [7:0]             r_beat_cnt;
  logic [RDATA_WIDTH-1:0] r_rdata;
  logic [1:0]             r_rresp;
  logic                   r_rlast;
  logic [ARID_WIDTH-1:0]  r_rid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_mem_rd_en = 1'b0;
    case (r_state)
      S_IDLE: if (!w_fifo_empty) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_pop       = 1'b1;
        // Error bursts never touch memory, so they skip READ entirely.
        w_state_nxt = w_head_err ? S_CAPT : S_READ;
      end
      S_READ: begin
        w_mem_rd_en = 1'b1;
        w_state_nxt = S_CAPT;
      end
      S_CAPT: w_state_nxt = S_DATA;
      S_DATA: begin
        if (RREADY) begin
          if (r_rlast)    w_state_nxt = S_IDLE;
          else if (r_err) w_state_nxt = S_CAPT;
          else            w_state_nxt = S_READ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- next beat address
  logic [AW-1:0] w_step;
  logic [AW-1:0] w_addr_inc;
  logic [AW-1:0] w_wrap_mask;
  logic [AW-1:0] w_addr_nxt;

  assign w_step      = AW'(1) << r_size;
  assign w_addr_inc  = r_addr + w_step;
  // Container size minus one: the low bits that step and wrap; bits above it stay put.
  assign w_wrap_mask = ((AW'(r_len) + AW'(1)) << r_size) - AW'(1);

  always_comb begin
    w_addr_nxt = w_addr_inc;
    case (r_burst)
      BURST_FIXED: w_addr_nxt = r_addr;
      BURST_WRAP:  w_addr_nxt = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      default:     w_addr_nxt = w_addr_inc;
    endcase
  end

  // ---------------------------------------------------------------- burst context and R registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_err      <= 1'b0;
      r_beat_cnt <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
      r_rlast    <= 1'b0;
      r_rid      <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_id       <= w_head_cmd.id;
          r_addr     <= w_head_cmd.addr;
          r_len      <= w_head_cmd.len;
          r_size     <= w_head_cmd.size;
          r_burst    <= w_head_cmd.burst;
          r_err      <= w_head_err;
          r_beat_cnt <= '0;
        end
        S_CAPT: begin
          r_rdata <= r_err ? '0 : mem_rd_data;
          r_rresp <= r_err ? 2'b10 : 2'b00;
          r_rlast <= (r_beat_cnt == r_len);
          r_rid   <= r_id;
        end
        S_DATA: begin
          if (RREADY && !r_rlast) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            r_addr     <= w_addr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign RVALID      = (r_state == S_DATA);
  assign RID         = r_rid;
  assign RDATA       = r_rdata;
  assign RRESP       = r_rresp;
  assign RLAST       = r_rlast;
  assign mem_rd_en   = w_mem_rd_en;
  assign mem_rd_addr = r_addr[AW-1:WB];

  logic w_unused;
  assign w_unused = ^ARREGION;

endmodule

// File: tb/tb_axi_rd_resp.sv
module tb_axi_rd_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ARID;
  logic [9:0]  ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARREGION;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        mem_rd_en;
  logic [6:0]  mem_rd_addr;
  logic [63:0] mem_rd_data;

  always #5 clk = ~clk;

  axi_rd_resp dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // ---------------------------------------------------------------- storage model
  logic [63:0] mem [128];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 64'h0123_4567_0000_0000 + 64'(i) * 64'h0000_0001_0000_0101;
    mem[2] = 64'hA5;
  end

  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 64'hDEAD_BEEF_DEAD_BEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- reference model
  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    addr_q[$];
  int    mem_log[$];
  int    rid_log[$];
  beat_t cur;
  logic [63:0] last_rdata;
  logic [3:0]  last_rid;
  logic [1:0]  last_rresp;
  logic        last_rlast;
  int    beats_seen = 0;
  int    hs_cyc = 0;
  int    rv_rise_cyc = 0;
  logic  rv_prev = 1'b0;

  function automatic int beat_addr(int addr, int len, int size, int burst, int k);
    int sz = 1 << size;
    int cont;
    int base;
    if (burst == 0) return addr;
    if (burst == 2) begin
      cont = (len + 1) * sz;
      base = (addr / cont) * cont;
      return base + ((addr - base) + k * sz) % cont;
    end
    return (addr + k * sz) % 1024;
  endfunction

  function automatic bit is_err(int addr, int len, int size, int burst);
    if (burst == 3) return 1'b1;
    if (size > 3) return 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    if (burst == 2 && (addr % (1 << size)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_push(int id, int addr, int len, int size, int burst);
    bit    err = is_err(addr, len, size, burst);
    beat_t b;
    int    a;
    for (int k = 0; k <= len; k++) begin
      a      = beat_addr(addr, len, size, burst, k);
      b.id   = 4'(id);
      b.resp = err ? 2'b10 : 2'b00;
      b.data = err ? 64'h0 : mem[(a >> 3) % 128];
      b.last = (k == len);
      exp_q.push_back(b);
      if (!err) addr_q.push_back(a >> 3);
    end
  endtask

  // Single compare process: every cycle outputs are meaningful, the DUT must match the model head.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      addr_q.delete();
      rv_prev = 1'b0;
    end else begin
      if (ARVALID && ARREADY)
        model_push(int'(ARID), int'(ARADDR), int'(ARLEN), int'(ARSIZE), int'(ARBURST));
      if (mem_rd_en) begin
        mem_log.push_back(int'(mem_rd_addr));
        if (addr_q.size() == 0) fail("mem_rd_en_unexpected");
        else chk("mem_rd_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
      end
      if (RVALID) begin
        if (exp_q.size() == 0) fail("rvalid_unexpected");
        else begin
          chk("rid",   64'(RID),   64'(exp_q[0].id));
          chk("rdata", RDATA,      exp_q[0].data);
          chk("rresp", 64'(RRESP), 64'(exp_q[0].resp));
          chk("rlast", 64'(RLAST), 64'(exp_q[0].last));
          if (RREADY) begin
            cur = exp_q.pop_front();
            last_rdata = RDATA;
            last_rid   = RID;
            last_rresp = RRESP;
            last_rlast = RLAST;
            beats_seen++;
            rid_log.push_back(int'(RID));
          end
        end
      end
      if (RVALID && !rv_prev) rv_rise_cyc = cyc;
      rv_prev = RVALID;
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  logic [3:0] rr_pat = 4'b1111;
  logic [1:0] rr_ph  = 2'd0;

  initial begin
    RREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      RREADY = rr_pat[rr_ph];
      rr_ph  = rr_ph + 2'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ar(input logic [3:0] id, input logic [9:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, output int stalls);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARREGION = ~id;
    ARVALID = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!ARREADY) begin
      stalls++;
      if (stalls > 300) begin
        fail("ar_accept_timeout");
        ARVALID = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    hs_cyc  = cyc;
    ARVALID = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || RVALID) && n <= budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n > budget) fail(name);
    chk("mem_reads_outstanding", 64'(addr_q.size()), 64'd0);
  endtask

  task automatic clear_logs();
    mem_log.delete();
    rid_log.delete();
    beats_seen = 0;
  endtask

  // ---------------------------------------------------------------- directed tests
  int st;
  int st_sum;
  int n;

  initial begin
    rst = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0;
    ARSIZE = '0; ARBURST = '0; ARREGION = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_arready",  64'(ARREADY), 64'd0);
    chk("reset_rvalid",   64'(RVALID), 64'd0);
    chk("reset_rlast",    64'(RLAST), 64'd0);
    chk("reset_rresp",    64'(RRESP), 64'd0);
    chk("reset_rid",      64'(RID), 64'd0);
    chk("reset_rdata",    RDATA, 64'd0);
    chk("reset_mem_rd_en",   64'(mem_rd_en), 64'd0);
    chk("reset_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("arready_after_release", 64'(ARREADY), 64'd1);
    step();

    // single beat
    clear_logs(); rr_pat = 4'b1111;
    ar(4'd3, 10'h010, 8'd0, 3'd3, 2'b01, st);
    wait_done("single_timeout", 50);
    chk("single_mem_reads", 64'(mem_log.size()), 64'd1);
    chk("single_mem_addr",  64'(mem_log[0]), 64'd2);
    chk("single_latency",   64'(rv_rise_cyc - hs_cyc), 64'd4);
    chk("single_rdata",     last_rdata, 64'hA5);
    chk("single_rid",       64'(last_rid), 64'd3);
    chk("single_rresp",     64'(last_rresp), 64'd0);
    chk("single_rlast",     64'(last_rlast), 64'd1);

    // INCR with RREADY toggling 1,0,0,1
    clear_logs(); rr_pat = 4'b1001;
    ar(4'd5, 10'h020, 8'd3, 3'd3, 2'b01, st);
    wait_done("incr_timeout", 100);
    chk("incr_beats", 64'(beats_seen), 64'd4);
    chk("incr_addr0", 64'(mem_log[0]), 64'd4);
    chk("incr_addr1", 64'(mem_log[1]), 64'd5);
    chk("incr_addr2", 64'(mem_log[2]), 64'd6);
    chk("incr_addr3", 64'(mem_log[3]), 64'd7);

    // WRAP 4 x 8 bytes from 0x30
    clear_logs(); rr_pat = 4'b1111;
    ar(4'd6, 10'h030, 8'd3, 3'd3, 2'b10, st);
    wait_done("wrap_timeout", 100);
    chk("wrap_addr0", 64'(mem_log[0]), 64'd6);
    chk("wrap_addr1", 64'(mem_log[1]), 64'd7);
    chk("wrap_addr2", 64'(mem_log[2]), 64'd4);
    chk("wrap_addr3", 64'(mem_log[3]), 64'd5);
    chk("wrap_rresp", 64'(last_rresp), 64'd0);

    // FIFO fill with RREADY held low: 4 queued + 1 already popped into the FSM
    clear_logs(); rr_pat = 4'b0000;
    st_sum = 0;
    for (int i = 1; i <= 5; i++) begin
      ar(4'(i), 10'(10'h040 + 8 * i), 8'd0, 3'd3, 2'b01, st);
      st_sum += st;
    end
    chk("fifo_no_stall", 64'(st_sum), 64'd0);
    @(negedge clk);
    chk("fifo_full_arready", 64'(ARREADY), 64'd0);
    repeat (3) step();
    @(negedge clk);
    chk("fifo_full_hold", 64'(ARREADY), 64'd0);
    rr_pat = 4'b1111;
    wait_done("fifo_timeout", 200);
    chk("fifo_rid_count", 64'(rid_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("fifo_rid_order", 64'(rid_log[i]), 64'(i + 1));

    // error bursts: reserved type, oversize beat, misaligned WRAP, bad WRAP length
    clear_logs();
    ar(4'd7, 10'h000, 8'd1, 3'd3, 2'b11, st);
    wait_done("err_rsvd_timeout", 50);
    chk("err_rsvd_mem_reads", 64'(mem_log.size()), 64'd0);
    chk("err_rsvd_beats",     64'(beats_seen), 64'd2);
    chk("err_rsvd_rresp",     64'(last_rresp), 64'd2);
    chk("err_rsvd_rdata",     last_rdata, 64'd0);
    chk("err_rsvd_rlast",     64'(last_rlast), 64'd1);
    clear_logs();
    ar(4'd8, 10'h008, 8'd1, 3'd4, 2'b01, st);
    wait_done("err_size_timeout", 50);
    chk("err_size_mem_reads", 64'(mem_log.size()), 64'd0);
    chk("err_size_beats",     64'(beats_seen), 64'd2);
    chk("err_size_rresp",     64'(last_rresp), 64'd2);
    clear_logs();
    ar(4'hD, 10'h034, 8'd3, 3'd3, 2'b10, st);
    ar(4'hE, 10'h030, 8'd2, 3'd3, 2'b10, st);
    wait_done("err_wrap_timeout", 100);
    chk("err_wrap_mem_reads", 64'(mem_log.size()), 64'd0);
    chk("err_wrap_beats",     64'(beats_seen), 64'd7);

    // FIXED and narrow INCR
    clear_logs();
    ar(4'hA, 10'h018, 8'd2, 3'd3, 2'b00, st);
    ar(4'hB, 10'h004, 8'd3, 3'd2, 2'b01, st);
    wait_done("fixed_narrow_timeout", 100);
    chk("fixed_addr2",  64'(mem_log[2]), 64'd3);
    chk("narrow_addr1", 64'(mem_log[4]), 64'd1);
    chk("narrow_addr3", 64'(mem_log[6]), 64'd2);

    // 256-beat burst wraps around the 1 KiB space
    clear_logs();
    ar(4'hC, 10'h000, 8'd255, 3'd3, 2'b01, st);
    wait_done("long_timeout", 1200);
    chk("long_beats",     64'(beats_seen), 64'd256);
    chk("long_addr128",   64'(mem_log[128]), 64'd0);
    chk("long_addr255",   64'(mem_log[255]), 64'd127);
    chk("long_rlast",     64'(last_rlast), 64'd1);

    // reset while beat 2 of 4 is presented
    clear_logs(); rr_pat = 4'b1001;
    ar(4'd4, 10'h020, 8'd3, 3'd3, 2'b01, st);
    n = 0;
    while (!(beats_seen == 1 && RVALID) && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 100) fail("reset_beat2_timeout");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_rvalid",  64'(RVALID), 64'd0);
    chk("rst_mid_arready", 64'(ARREADY), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_rvalid", 64'(RVALID), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_arready", 64'(ARREADY), 64'd1);
    step();
    clear_logs(); rr_pat = 4'b1111;
    ar(4'd9, 10'h010, 8'd0, 3'd3, 2'b01, st);
    wait_done("post_reset_timeout", 50);
    chk("post_reset_beats", 64'(beats_seen), 64'd1);
    chk("post_reset_rid",   64'(last_rid), 64'd9);
    chk("post_reset_rdata", last_rdata, 64'hA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    fail("global_timeout");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
